reg_wb_arbiter: RTL and testbench
=================================

Name: reg_wb_arbiter

Overview:
Write-back controller for the 2-read/1-write register file. Shares its single write port (c_reg/c_writedatain/c_we) between two producers: ALU write-back (req0) and load write-back (req1). Keeps a per-register pending-write scoreboard so that the issue stage can stall reads of registers that have an outstanding write. Sits between the execute/memory stages and the register file.

Parameters:
WIDTH, 32, data width of a register
NUMREGS, 32, number of registers
LOG2NUMREGS, 5, register index width
STARVE_LIMIT, 4, number of consecutive cycles req1 may be denied before it is forced to win

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
req0_valid  in  1  ALU write-back request
req0_ready  out  1  req0 accepted this cycle
req0_reg  in  LOG2NUMREGS  ALU destination register
req0_data  in  WIDTH  ALU result
req1_valid  in  1  load write-back request
req1_ready  out  1  req1 accepted this cycle
req1_reg  in  LOG2NUMREGS  load destination register
req1_data  in  WIDTH  load data
sb_set  in  1  issue stage marks a register as pending
sb_set_reg  in  LOG2NUMREGS  register to mark
a_reg, b_reg  in  LOG2NUMREGS each  read-port register indices from the issue stage
a_en, b_en  in  1 each  read-port enables
a_busy, b_busy  out  1 each  read operand has a pending write
sb_overflow  out  1  sticky flag: sb_set was applied to a register that was already pending
c_reg  out  LOG2NUMREGS  register file write address
c_writedatain  out  WIDTH  register file write data
c_we  out  1  register file write enable

Behaviour:
- Reset (asynchronous, resetn=0):
  - c_we=0, c_reg=0, c_writedatain=0.
  - All pending bits=0, starvation counter=0, sb_overflow=0.
  - A write in flight at reset is dropped; producers reissue it.
- Accepting a request:
  - A request is accepted in the cycle where valid && ready.
  - The ready outputs are combinational from the valids and the arbitration state.
  - At most one ready is high in any cycle.
- Arbitration: req0 has fixed priority, with one exception.
  - starve_cnt increments each cycle in which req1_valid && !req1_ready. It saturates at STARVE_LIMIT.
  - starve_cnt clears whenever req1 is accepted.
  - When starve_cnt==STARVE_LIMIT and req1_valid, req1 wins and req0_ready=0.
- Write port timing: registered, with latency 1.
  - The edge that accepts a request loads c_reg and c_writedatain and sets c_we=1 for exactly one cycle.
  - With no acceptance, c_we=0 and c_reg/c_writedatain hold their values.
- Register 0:
  - A request to r0 is accepted (ready high) but produces c_we=0.
  - sb_set to r0 is ignored.
  - a_busy/b_busy are never asserted for r0.
- Scoreboard, one pending bit per register:
  - Set: sb_set sets pending[sb_set_reg] at the edge.
  - Clear: the edge at the end of a c_we=1 cycle clears pending[c_reg].
  - Set and clear of the same register in the same cycle: set wins.
  - sb_set to a register that is already pending (and not being cleared that cycle) sets sb_overflow. sb_overflow stays set until reset.
- Busy outputs (combinational):
  - a_busy = a_en && a_reg!=0 && pending[a_reg]. b_busy follows the same rule.
  - A committing write is still reported busy in its c_we cycle; it reads not-busy from the next cycle on.

Optional Feature:
Macro: REG_WB_ARBITER_FORWARD_EN.
- When defined, adds outputs a_fwd (1), a_fwd_data (WIDTH), b_fwd (1) and b_fwd_data (WIDTH).
- a_fwd = c_we && a_en && a_reg==c_reg && a_reg!=0. a_fwd_data = c_writedatain.
- a_busy is masked to 0 while a_fwd=1. b_fwd and b_busy follow the same rules.
- When the macro is not defined, these ports do not exist and busy follows the base rule.

Decomposition:
- Shared package:
  - WIDTH, LOG2NUMREGS and NUMREGS defaults
  - requester-ID enum (WB_ALU=0, WB_LOAD=1)
  - STARVE_LIMIT default
- Sub-module reg_scoreboard:
  - contains the pending array, set/clear priority, sb_overflow and busy lookups
  - the arbiter and write-port registers stay in the top module

Test Plan:
1. req0 (r5, 0x11) and req1 (r6, 0x22) both valid in one cycle: req0_ready=1, and the next cycle has c_we=1, c_reg=5, c_writedatain=0x11. req1 is accepted in the following cycle.
2. req0 held valid continuously and req1 valid for 5 cycles: req1 is denied for 4 cycles, wins on the 5th (req0_ready=0 that cycle), and starve_cnt returns to 0.
3. req0 to r0 with data 0xdead: req0_ready=1 and c_we stays 0. sb_set to r0 leaves a_busy=0 with a_reg=0.
4. sb_set r7, then a_reg=7 with a_en=1: a_busy=1 until the cycle after the c_we=1 write of r7, then 0. A second sb_set r7 issued before that write sets sb_overflow=1.
5. sb_set r9 in the same cycle as a c_we=1 write of r9: r9 remains pending and sb_overflow stays 0.
6. resetn driven low while c_we=1: c_we=0 and all busy outputs read 0 immediately. With REG_WB_ARBITER_FORWARD_EN, a c_we cycle where a_reg==c_reg gives a_fwd=1, a_fwd_data=c_writedatain and a_busy=0.

Source files
------------

// File: rtl/reg_wb_arbiter_pkg.sv
// Shared defaults and requester IDs for the register-file write-back arbiter.
package reg_wb_arbiter_pkg;
  localparam int WB_WIDTH        = 32;
  localparam int WB_NUMREGS      = 32;
  localparam int WB_LOG2NUMREGS  = 5;
  localparam int WB_STARVE_LIMIT = 4;

  typedef enum logic {
    WB_ALU  = 1'b0,
    WB_LOAD = 1'b1
  } wb_req_e;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write bits with set-over-clear priority, sticky
// overflow on a double mark, and read-port busy lookups.
module reg_scoreboard #(
  parameter int NUMREGS     = 32,
  parameter int LOG2NUMREGS = 5
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   set,
  input  logic [LOG2NUMREGS-1:0] set_reg,
  input  logic                   clr,
  input  logic [LOG2NUMREGS-1:0] clr_reg,
  input  logic [LOG2NUMREGS-1:0] a_reg,
  input  logic                   a_en,
  input  logic [LOG2NUMREGS-1:0] b_reg,
  input  logic                   b_en,
  output logic                   a_busy,
  output logic                   b_busy,
  output logic                   overflow
);
  logic [NUMREGS-1:0] pending, pending_nxt;
  logic               set_ok, dbl_mark;

  // r0 is hard-wired, so it is never tracked.
  assign set_ok   = set && (set_reg != '0);
  assign dbl_mark = set_ok && pending[set_reg] && !(clr && clr_reg == set_reg);

  always_comb begin
    pending_nxt = pending;
    if (clr)    pending_nxt[clr_reg] = 1'b0;
    if (set_ok) pending_nxt[set_reg] = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (dbl_mark) overflow <= 1'b1;
    end
  end

  assign a_busy = a_en && (a_reg != '0) && pending[a_reg];
  assign b_busy = b_en && (b_reg != '0) && pending[b_reg];
endmodule

// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter: shares the register-file write port between ALU and load
// producers. Optional bypass of the committing write: REG_WB_ARBITER_FORWARD_EN.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int WIDTH        = WB_WIDTH,
  parameter int NUMREGS      = WB_NUMREGS,
  parameter int LOG2NUMREGS  = WB_LOG2NUMREGS,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [LOG2NUMREGS-1:0] req0_reg,
  input  logic [WIDTH-1:0]       req0_data,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [LOG2NUMREGS-1:0] req1_reg,
  input  logic [WIDTH-1:0]       req1_data,
  input  logic                   sb_set,
  input  logic [LOG2NUMREGS-1:0] sb_set_reg,
  input  logic [LOG2NUMREGS-1:0] a_reg,
  input  logic [LOG2NUMREGS-1:0] b_reg,
  input  logic                   a_en,
  input  logic                   b_en,
  output logic                   a_busy,
  output logic                   b_busy,
  output logic                   sb_overflow,
`ifdef REG_WB_ARBITER_FORWARD_EN
  output logic                   a_fwd,
  output logic [WIDTH-1:0]       a_fwd_data,
  output logic                   b_fwd,
  output logic [WIDTH-1:0]       b_fwd_data,
`endif
  output logic [LOG2NUMREGS-1:0] c_reg,
  output logic [WIDTH-1:0]       c_writedatain,
  output logic                   c_we
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0]          starve_cnt;
  logic                   force_load, accept;
  wb_req_e                gnt_id;
  logic [LOG2NUMREGS-1:0] wr_reg;
  logic [WIDTH-1:0]       wr_data;
  logic                   a_busy_raw, b_busy_raw;

  // Load wins only once it has waited STARVE_LIMIT denied cycles.
  assign force_load = req1_valid && (starve_cnt == STARVE_MAX);
  assign req0_ready = req0_valid && !force_load;
  assign req1_ready = req1_valid && !req0_ready;
  assign accept     = req0_ready || req1_ready;
  assign gnt_id     = req1_ready ? WB_LOAD : WB_ALU;
  assign wr_reg     = (gnt_id == WB_LOAD) ? req1_reg  : req0_reg;
  assign wr_data    = (gnt_id == WB_LOAD) ? req1_data : req0_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (req1_ready) begin
      starve_cnt <= '0;
    end else if (req1_valid && starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // r0 writes are accepted and latched but never strobe the write enable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      c_we          <= 1'b0;
      c_reg         <= '0;
      c_writedatain <= '0;
    end else begin
      c_we <= accept && (wr_reg != '0);
      if (accept) begin
        c_reg         <= wr_reg;
        c_writedatain <= wr_data;
      end
    end
  end

  reg_scoreboard #(
    .NUMREGS     (NUMREGS),
    .LOG2NUMREGS (LOG2NUMREGS)
  ) u_sb (
    .clk      (clk),
    .resetn   (resetn),
    .set      (sb_set),
    .set_reg  (sb_set_reg),
    .clr      (c_we),
    .clr_reg  (c_reg),
    .a_reg    (a_reg),
    .a_en     (a_en),
    .b_reg    (b_reg),
    .b_en     (b_en),
    .a_busy   (a_busy_raw),
    .b_busy   (b_busy_raw),
    .overflow (sb_overflow)
  );

`ifdef REG_WB_ARBITER_FORWARD_EN
  assign a_fwd      = c_we && a_en && (a_reg == c_reg) && (a_reg != '0);
  assign b_fwd      = c_we && b_en && (b_reg == c_reg) && (b_reg != '0);
  assign a_fwd_data = c_writedatain;
  assign b_fwd_data = c_writedatain;
  assign a_busy     = a_busy_raw && !a_fwd;
  assign b_busy     = b_busy_raw && !b_fwd;
`else
  assign a_busy     = a_busy_raw;
  assign b_busy     = b_busy_raw;
`endif
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios then random
// traffic, all compared against a behavioural model of the write-back rules.
module tb_reg_wb_arbiter;
  localparam int W = 32, N = 32, L = 5, SL = 4;

  logic         clk = 1'b0, resetn;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [L-1:0] req0_reg, req1_reg, sb_set_reg, a_reg, b_reg, c_reg;
  logic [W-1:0] req0_data, req1_data, c_writedatain;
  logic         sb_set, a_en, b_en, a_busy, b_busy, sb_overflow, c_we;
`ifdef REG_WB_ARBITER_FORWARD_EN
  logic         a_fwd, b_fwd;
  logic [W-1:0] a_fwd_data, b_fwd_data;
`endif

  reg_wb_arbiter dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_reg(req0_reg), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_reg(req1_reg), .req1_data(req1_data),
    .sb_set(sb_set), .sb_set_reg(sb_set_reg),
    .a_reg(a_reg), .b_reg(b_reg), .a_en(a_en), .b_en(b_en),
    .a_busy(a_busy), .b_busy(b_busy), .sb_overflow(sb_overflow),
`ifdef REG_WB_ARBITER_FORWARD_EN
    .a_fwd(a_fwd), .a_fwd_data(a_fwd_data), .b_fwd(b_fwd), .b_fwd_data(b_fwd_data),
`endif
    .c_reg(c_reg), .c_writedatain(c_writedatain), .c_we(c_we)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference model: pending set, waiting-cycle count, last committed write.
  bit         pend[N];
  int         starve;
  bit         m_we, m_ovf;
  int         m_reg;
  logic [W-1:0] m_data;
  bit         obs_r0, obs_r1, obs_we, obs_ab, obs_bb, obs_ovf;

  task automatic model_reset();
    foreach (pend[i]) pend[i] = 1'b0;
    starve = 0; m_we = 0; m_ovf = 0; m_reg = 0; m_data = '0;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; req0_reg = '0; req1_reg = '0;
    req0_data = '0; req1_data = '0; sb_set = 0; sb_set_reg = '0;
    a_reg = '0; b_reg = '0; a_en = 0; b_en = 0;
  endtask

  function automatic bit exp_fwd(input bit en, input int r);
`ifdef REG_WB_ARBITER_FORWARD_EN
    return m_we && en && r == m_reg && r != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Inputs are already applied (posedge+1). Check mid-cycle, advance model, clock.
  task automatic step();
    bit e0, e1, fa, fb, clr, sok;
    int cr;
    #3;
    e0 = req0_valid && !(req1_valid && starve == SL);
    e1 = req1_valid && !e0;
    fa = exp_fwd(a_en, int'(a_reg));
    fb = exp_fwd(b_en, int'(b_reg));
    check("req0_ready", req0_ready, e0);
    check("req1_ready", req1_ready, e1);
    check("c_we", c_we, m_we);
    check("c_reg", c_reg, m_reg);
    check("c_writedatain", c_writedatain, m_data);
    check("a_busy", a_busy, a_en && a_reg != 0 && pend[a_reg] && !fa);
    check("b_busy", b_busy, b_en && b_reg != 0 && pend[b_reg] && !fb);
    check("sb_overflow", sb_overflow, m_ovf);
`ifdef REG_WB_ARBITER_FORWARD_EN
    check("a_fwd", a_fwd, fa);
    check("b_fwd", b_fwd, fb);
    if (fa) check("a_fwd_data", a_fwd_data, m_data);
    if (fb) check("b_fwd_data", b_fwd_data, m_data);
`endif
    obs_r0 = req0_ready; obs_r1 = req1_ready; obs_we = c_we;
    obs_ab = a_busy; obs_bb = b_busy; obs_ovf = sb_overflow;

    clr = m_we; cr = m_reg;
    sok = sb_set && sb_set_reg != 0;
    if (sok && pend[sb_set_reg] && !(clr && cr == int'(sb_set_reg))) m_ovf = 1;
    if (clr) pend[cr] = 0;
    if (sok) pend[sb_set_reg] = 1;
    if (e1) starve = 0;
    else if (req1_valid && starve < SL) starve++;
    if (e0) begin
      m_we = req0_reg != 0; m_reg = int'(req0_reg); m_data = req0_data;
    end else if (e1) begin
      m_we = req1_reg != 0; m_reg = int'(req1_reg); m_data = req1_data;
    end else m_we = 0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    a_en = 1; a_reg = 5'd1; b_en = 1; b_reg = 5'd2;
    resetn = 0;
    model_reset();
    #1;
    check("rst c_we", c_we, 0);
    check("rst c_reg", c_reg, 0);
    check("rst c_writedatain", c_writedatain, 0);
    check("rst sb_overflow", sb_overflow, 0);
    check("rst a_busy", a_busy, 0);
    @(posedge clk); #2;
    resetn = 1;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // 1: both valid, ALU wins, load follows.
    req0_valid = 1; req0_reg = 5; req0_data = 32'h11;
    req1_valid = 1; req1_reg = 6; req1_data = 32'h22;
    step();
    check("t1 r0 wins", obs_r0, 1);
    check("t1 r1 denied", obs_r1, 0);
    req0_valid = 0;
    step();
    check("t1 we", obs_we, 1);
    check("t1 r1 accepted", obs_r1, 1);
    req1_valid = 0;
    step();
    check("t1 load c_reg", c_reg, 6);

    // 2: starvation forcing.
    req0_valid = 1; req0_reg = 3; req1_valid = 1; req1_reg = 4;
    for (int i = 0; i < 5; i++) begin
      req0_data = 32'h100 + i; req1_data = 32'h200 + i;
      step();
      check("t2 r1 ready", obs_r1, i == 4);
      check("t2 r0 ready", obs_r0, i != 4);
    end
    step();
    check("t2 starve cleared", obs_r1, 0);
    idle_inputs();
    step();

    // 3: r0 accepted without a write; r0 never busy.
    req0_valid = 1; req0_reg = 0; req0_data = 32'hdead;
    step();
    check("t3 r0 ready", obs_r0, 1);
    idle_inputs();
    sb_set = 1; sb_set_reg = 0; a_en = 1; a_reg = 0;
    step();
    check("t3 no we", obs_we, 0);
    sb_set = 0;
    step();
    check("t3 a_busy r0", obs_ab, 0);

    // 4: busy until commit, double mark overflows.
    sb_set = 1; sb_set_reg = 7;
    step();
    a_reg = 7;
    step();
    check("t4 busy", obs_ab, 1);
    sb_set = 0;
    step();
    check("t4 ovf", obs_ovf, 1);
    req0_valid = 1; req0_reg = 7; req0_data = 32'h77;
    step();
    req0_valid = 0;
    step();
`ifdef REG_WB_ARBITER_FORWARD_EN
    check("t4 busy in we (fwd)", obs_ab, 0);
`else
    check("t4 busy in we", obs_ab, 1);
`endif
    step();
    check("t4 not busy", obs_ab, 0);

    // 5: set and clear same register, set wins without overflow.
    do_reset();
    sb_set = 1; sb_set_reg = 9;
    step();
    sb_set = 0; req0_valid = 1; req0_reg = 9; req0_data = 32'h99;
    step();
    req0_valid = 0; sb_set = 1; sb_set_reg = 9;
    step();
    sb_set = 0; a_en = 1; a_reg = 9;
    step();
    check("t5 still pending", obs_ab, 1);
    check("t5 no ovf", obs_ovf, 0);

    // 6: reset during a write, plus forwarding check.
    idle_inputs();
    sb_set = 1; sb_set_reg = 3;
    step();
    sb_set = 0; req0_valid = 1; req0_reg = 3; req0_data = 32'hc0de;
    a_en = 1; a_reg = 3; b_en = 1; b_reg = 9;
    step();
    req0_valid = 0;
    #1;
    check("t6 we before rst", c_we, 1);
`ifdef REG_WB_ARBITER_FORWARD_EN
    check("t6 a_fwd", a_fwd, 1);
    check("t6 a_fwd_data", a_fwd_data, 32'hc0de);
    check("t6 a_busy masked", a_busy, 0);
`endif
    resetn = 0;
    model_reset();
    #1;
    check("t6 rst we", c_we, 0);
    check("t6 rst a_busy", a_busy, 0);
    check("t6 rst b_busy", b_busy, 0);
    @(posedge clk); #2;
    resetn = 1;
    @(posedge clk); #1;

    // Random traffic on a narrow register range to force collisions.
    for (int c = 0; c < 600; c++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_reg   = 5'($urandom_range(0, 7));
      req1_reg   = 5'($urandom_range(0, 7));
      req0_data  = $urandom;
      req1_data  = $urandom;
      sb_set     = ($urandom_range(0, 3) == 0);
      sb_set_reg = 5'($urandom_range(0, 7));
      a_en       = 1'($urandom);
      b_en       = 1'($urandom);
      a_reg      = 5'($urandom_range(0, 7));
      b_reg      = 5'($urandom_range(0, 7));
      step();
      if (c == 300) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
